// File: rtl/pio_pkg.sv
// pio_pkg: register map, edge-mode encodings and sizing helper shared by the PIO blocks
package pio_pkg;
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
    // debounce counter width; a bypassed debouncer still gets a legal 1-bit width
    function automatic int cnt_width(input int d);
        return (d > 0 ? $clog2(d) : 0) + 1;
    endfunction
endpackage

// File: rtl/pio_in_debounce.sv
// pio_in_debounce: one-bit synchroniser followed by an optional debounce filter
//   clk, reset_n : clock and asynchronous active-low reset
//   din          : asynchronous input bit
//   level        : synchronised (and debounced) level
module pio_in_debounce
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign level = sync;
        end else begin : g_deb
            localparam int CW = cnt_width(DEBOUNCE_CYCLES);
            logic [CW-1:0] cnt;
            logic          lvl_q;
            // counts consecutive cycles the synchronised input disagrees with the
            // accepted level; the level only moves after a full run of disagreement
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) begin
                    cnt   <= '0;
                    lvl_q <= 1'b0;
                end else if (sync == lvl_q) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_q <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            assign level = lvl_q;
        end
    endgenerate
endmodule

// File: rtl/button_edge_pio.sv
// button_edge_pio: Avalon-MM input PIO with edge capture and masked level interrupt
//   clk, reset_n        : clock and asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata  : Avalon-MM slave write/address inputs
//   readdata            : registered read data, one cycle after address
//   irq                 : |(edge_capture & irq_mask)
//   in_port             : asynchronous external inputs
module button_edge_pio
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);
    logic [WIDTH-1:0] level, level_d, edge_capture, irq_mask;
    logic [WIDTH-1:0] rise, fall, edge_det, w1c;
    logic             wr;
    logic             unused_wd;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .level  (level[i])
        );
    end

    assign wr        = chipselect & ~write_n;
    assign rise      = level & ~level_d;
    assign fall      = ~level & level_d;
    assign edge_det  = EDGE_TYPE == EDGE_RISE ? rise :
                       EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
    assign w1c       = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            level_d      <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            level_d      <= level;
            // a new edge beats a simultaneous clear so no event is lost
            edge_capture <= edge_det | (edge_capture & ~w1c);
            if (wr && address == PIO_ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
            // read mux ignores chipselect; DIRECTION reads as zero
            readdata     <= address == PIO_ADDR_DATA    ? 32'(level)        :
                            address == PIO_ADDR_IRQMASK ? 32'(irq_mask)     :
                            address == PIO_ADDR_EDGECAP ? 32'(edge_capture) : '0;
        end

    assign irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_button_edge_pio.sv
// tb_button_edge_pio: three PIO configurations driven in parallel against a history-based reference model
module tb_button_edge_pio;
    localparam int N = 3;
    localparam int SS [N] = '{2, 2, 3};
    localparam int DD [N] = '{0, 4, 2};
    localparam int ET [N] = '{1, 1, 2};

    typedef struct packed {
        logic [31:0] e2;
        logic [31:0] e1;
        logic [31:0] e0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_port = 8'd0;
    logic [31:0] rdv [N];
    logic        irqv [N];
    logic        rd_req = 1'b0;
    logic        rd_valid_q;

    int tests = 0;
    int fails = 0;

    exp_t       sbq [$];
    logic [7:0] hist [$];
    logic [7:0] lvl [N];
    logic [7:0] lvl1 [N];
    logic [7:0] cap [N];
    logic [7:0] msk [N];

    always #5 clk = ~clk;

    button_edge_pio #(.WIDTH(8), .EDGE_TYPE(ET[0]), .SYNC_STAGES(SS[0]), .DEBOUNCE_CYCLES(DD[0])) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdv[0]), .irq(irqv[0]), .in_port(in_port));
    button_edge_pio #(.WIDTH(8), .EDGE_TYPE(ET[1]), .SYNC_STAGES(SS[1]), .DEBOUNCE_CYCLES(DD[1])) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdv[1]), .irq(irqv[1]), .in_port(in_port));
    button_edge_pio #(.WIDTH(8), .EDGE_TYPE(ET[2]), .SYNC_STAGES(SS[2]), .DEBOUNCE_CYCLES(DD[2])) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdv[2]), .irq(irqv[2]), .in_port(in_port));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // read response marker: a read issued in one cycle is answered after the next edge
    always @(posedge clk or negedge reset_n)
        if (!reset_n) rd_valid_q <= 1'b0;
        else          rd_valid_q <= rd_req;

    always @(negedge clk)
        if (rd_valid_q) begin
            exp_t x;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_underflow: got response expected none");
            end else begin
                x = sbq.pop_front();
                chk("readdata0", rdv[0], x.e0);
                chk("readdata1", rdv[1], x.e1);
                chk("readdata2", rdv[2], x.e2);
            end
        end

    function automatic logic [7:0] smp_at(input int k);
        return (k < hist.size()) ? hist[hist.size() - 1 - k] : 8'h00;
    endfunction

    // level after this edge: plain delay when undebounced, otherwise a bit flips once
    // the last DD synchronised samples all disagree with the accepted level
    function automatic logic [7:0] next_level(input int i);
        logic [7:0] r, s;
        bit         all;
        if (DD[i] == 0) return smp_at(SS[i] - 1);
        r = lvl[i];
        for (int b = 0; b < 8; b++) begin
            all = 1'b1;
            for (int j = 0; j < DD[i]; j++) begin
                s = smp_at(SS[i] + j);
                if (s[b] == lvl[i][b]) all = 1'b0;
            end
            if (all) r[b] = ~lvl[i][b];
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N; i++) begin
            lvl[i] = 8'h00; lvl1[i] = 8'h00; cap[i] = 8'h00; msk[i] = 8'h00;
        end
    endtask

    task automatic step();
        logic [7:0] w1c, rise, fall, edg, nl;
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            w1c = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
            hist.push_back(in_port);
            if (hist.size() > 16) void'(hist.pop_front());
            for (int i = 0; i < N; i++) begin
                rise = lvl[i] & ~lvl1[i];
                fall = ~lvl[i] & lvl1[i];
                edg  = ET[i] == 0 ? rise : ET[i] == 1 ? fall : (rise | fall);
                nl   = next_level(i);
                cap[i] = edg | (cap[i] & ~w1c);
                if (chipselect && !write_n && address == 2'd2) msk[i] = writedata[7:0];
                lvl1[i] = lvl[i];
                lvl[i]  = nl;
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("irq%0d", i), 32'(irqv[i]), 32'(|(cap[i] & msk[i])));
    endtask

    function automatic logic [31:0] reg_val(input int i, input logic [1:0] a);
        return a == 2'd0 ? 32'(lvl[i]) : a == 2'd2 ? 32'(msk[i]) : a == 2'd3 ? 32'(cap[i]) : 32'd0;
    endfunction

    task automatic cyc(input logic [1:0] a, input bit wr, input logic [31:0] wd, input bit rd);
        address = a; chipselect = wr; write_n = !wr; writedata = wd; rd_req = rd;
        if (rd) sbq.push_back('{e2: reg_val(2, a), e1: reg_val(1, a), e0: reg_val(0, a)});
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'd3, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic do_reset();
        rd_req = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        step();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_readdata%0d", i), rdv[i], 32'd0);
            chk($sformatf("rst_irq%0d", i), 32'(irqv[i]), 32'd0);
        end
        repeat (3) begin
            in_port = 8'($urandom);
            step();
            for (int i = 0; i < N; i++) chk($sformatf("rst_hold_readdata%0d", i), rdv[i], 32'd0);
        end
        in_port = 8'h00;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        repeat (3) begin
            in_port = 8'($urandom);
            step();
            for (int i = 0; i < N; i++) chk($sformatf("por_readdata%0d", i), rdv[i], 32'd0);
        end
        in_port = 8'h00;
        reset_n = 1'b1;
        cyc(2'd2, 1'b0, 32'd0, 1'b1);
        cyc(2'd3, 1'b0, 32'd0, 1'b1);
        // DATA read
        in_port = 8'hA5;
        repeat (3) cyc(2'd0, 1'b0, 32'd0, 1'b1);
        idle(6);
        cyc(2'd0, 1'b0, 32'd0, 1'b1);
        cyc(2'd1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cyc(2'd1, 1'b0, 32'd0, 1'b1);
        // falling edge on bit0 with mask, clear, then rising edge
        cyc(2'd3, 1'b1, 32'hFF, 1'b0);
        cyc(2'd2, 1'b1, 32'h01, 1'b0);
        in_port[0] = 1'b0;
        idle(8);
        cyc(2'd3, 1'b1, 32'h01, 1'b0);
        idle(2);
        in_port[0] = 1'b1;
        idle(8);
        // bit3 falling edge landing together with a clear of bit3
        in_port[3] = 1'b1;
        idle(10);
        cyc(2'd3, 1'b1, 32'hFF, 1'b0);
        in_port[3] = 1'b0;
        idle(2);
        cyc(2'd3, 1'b1, 32'h08, 1'b1);
        idle(2);
        cyc(2'd3, 1'b1, 32'h08, 1'b1);
        cyc(2'd3, 1'b1, 32'h08, 1'b1);
        idle(4);
        // debounce: 3-cycle glitch then 4-cycle low on bit1
        in_port[1] = 1'b1;
        idle(12);
        cyc(2'd3, 1'b1, 32'hFF, 1'b0);
        in_port[1] = 1'b0;
        idle(3);
        in_port[1] = 1'b1;
        idle(10);
        cyc(2'd0, 1'b0, 32'd0, 1'b1);
        in_port[1] = 1'b0;
        idle(4);
        in_port[1] = 1'b1;
        idle(12);
        // mask behaviour, then reset in the middle of a debounce
        cyc(2'd3, 1'b1, 32'hFF, 1'b0);
        cyc(2'd2, 1'b1, 32'h00, 1'b0);
        in_port[2] = 1'b0;
        idle(8);
        cyc(2'd2, 1'b1, 32'h04, 1'b1);
        idle(2);
        cyc(2'd2, 1'b1, 32'h00, 1'b1);
        idle(2);
        cyc(2'd2, 1'b1, 32'h04, 1'b1);
        in_port[2] = 1'b1;
        idle(3);
        do_reset();
        idle(12);
        cyc(2'd2, 1'b0, 32'd0, 1'b1);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 4) == 0) in_port = in_port ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 9) < 2)
                cyc(2'($urandom_range(0, 3)), 1'b1, $urandom, 1'($urandom_range(0, 1)));
            else
                cyc(2'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b1);
        end
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/button_edge_pio.md
Name: button_edge_pio

Overview:
- Avalon-MM slave input PIO, the input counterpart of the LED output PIO.
- Samples an external WIDTH-bit input bus (push-buttons/switches), synchronises and optionally debounces it, then captures edges per bit.
- Raises a level-sensitive interrupt to the Nios II processor through a mask register.
- Sits on the same system interconnect as the output PIOs.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- EDGE_TYPE, 1, edge capture mode: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, flip-flop synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 0, consecutive equal samples required to accept a new level; 0 = bypass.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  2  Avalon word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  registered read data
- irq  output  1  level interrupt, active-high
- in_port  input  WIDTH  asynchronous external inputs

Behaviour:
- Clock/reset: reset reset_n, asynchronous, active-low; clock clk. All flops clear on reset_n low, including mid-debounce and mid-capture.
- Reset values: readdata = 0, irq = 0, irq_mask = 0, edge_capture = 0. Synchroniser and debounced level reset to 0.
- Input path: in_port passes through SYNC_STAGES flops to give sync.
- Debounce bypassed (DEBOUNCE_CYCLES = 0): level = sync.
- Debounce enabled, per bit:
  - Counter cleared whenever sync == level.
  - Counter increments while sync != level.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, level takes sync and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1 and does not wrap.
- Edge detect: level_d is level delayed by one cycle.
  - rise = level & ~level_d
  - fall = ~level & level_d
  - edge selected by EDGE_TYPE.
- Latency from in_port change to edge_capture set: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Register map (word address):
  - 0 DATA: read returns zero-extended level; writes ignored.
  - 1 DIRECTION: reads 0; writes ignored.
  - 2 IRQMASK: read/write, bits [WIDTH-1:0]; upper bits read 0.
  - 3 EDGECAPTURE: read returns captures; write-1-to-clear per bit.
- Write qualifier: chipselect & ~write_n. No wait states.
- Read timing: readdata is registered every cycle from the current address (mux then flop). Read latency is 1 cycle, and chipselect is not required for the read mux.
- edge_capture per bit, next state: set if edge, else clear if W1C of that bit, else hold.
- Simultaneous edge and W1C on the same bit: set wins, so no event is lost.
- irq = |(edge_capture & irq_mask), combinational from registers, no glitch path from in_port.
- Unmasking a bit with a pending capture asserts irq the next cycle.
- Masking that bit drops irq the next cycle; the capture itself stays set.
- Captures persist until cleared by software; there is no overflow or count.

Decomposition:
- Shared package pio_pkg:
  - address constants PIO_ADDR_DATA = 0, PIO_ADDR_DIR = 1, PIO_ADDR_IRQMASK = 2, PIO_ADDR_EDGECAP = 3.
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module pio_in_debounce: a single-bit synchroniser plus debounce counter with parameters SYNC_STAGES and DEBOUNCE_CYCLES, instantiated WIDTH times in a generate loop.
- Top level holds the edge detect, registers, read mux and irq.

Test Plan:
- Reset: hold reset_n low, toggle in_port -> readdata = 0, irq = 0. After release, read addr 2 and addr 3 -> 0x00000000.
- DATA read: DEBOUNCE_CYCLES = 0, in_port = 0xA5, wait SYNC_STAGES+1 cycles, read addr 0 -> readdata = 0x000000A5 exactly one cycle after address is presented.
- Edge and irq (EDGE_TYPE = 1): write 0x01 to addr 2; drive bit0 1 -> 0.
  - Addr 3 reads 0x01 and irq = 1.
  - Write 0x01 to addr 3 -> addr 3 reads 0x00, irq = 0.
  - A rising edge on bit0 sets nothing.
- Set-wins collision: arrange the bit3 falling edge to register in the same cycle as a write of 0x08 to addr 3 -> addr 3 reads 0x08 afterwards.
- Debounce (DEBOUNCE_CYCLES = 4): a 3-cycle low pulse on bit1 -> no capture, DATA unchanged. A 4-cycle low -> capture 0x02 exactly SYNC_STAGES+5 cycles after the input falls.
- Mask and reset mid-operation:
  - Capture bit2 with mask 0 -> irq = 0.
  - Write mask 0x04 -> irq = 1 next cycle.
  - Assert reset_n mid-debounce -> capture, mask and irq are 0 immediately, with no spurious edge after release.
